de1_soc_leds: RTL
=================

# de1_soc_leds

Avalon-MM memory-mapped output port driving the DE1-SoC red LEDs: the write-side counterpart of the switch input port. It holds a software-written output register with atomic set/clear aliases and a hardware blink engine that gates selected bits at a programmable rate. It sits on the lightweight HPS/Nios bridge next to the switch port and drives LEDR[9:0] through a registered output.

## Interface
- WIDTH, 10: number of output bits; must satisfy 1..32.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; must be ≥ 2. At 50 MHz the default gives 1 Hz.
- RESET_VALUE, 0: reset value of the DATA register, truncated to WIDTH bits.
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: reset. Asynchronous, active-high.
- address, input, 2: word address.
- write, input, 1: write strobe, single-cycle, no wait states.
- writedata, input, 32: write data; bits above WIDTH are ignored.
- read, input, 1: read strobe.
- readdata, output, 32: registered read data; bits above WIDTH read 0.
- out_port, output, WIDTH: registered LED drive.

## Operation
- **Register map (word addresses):**
  - 0 DATA: read/write.
  - 1 BLINK_MASK: read/write.
  - 2 OUTSET: write-1-to-set DATA bits; reads return 0.
  - 3 OUTCLEAR: write-1-to-clear DATA bits; reads return 0.
- **Blink prescaler:**
  - Counter `cnt` runs 0..BLINK_DIV-1, then wraps to 0.
  - `phase` toggles in the cycle where `cnt` wraps.
- **Output:** out_port = DATA & ~(BLINK_MASK & {WIDTH{phase}}).
  - phase=0 means every DATA bit is shown.
  - phase=1 blanks the masked bits.
- **BLINK_MASK write:** forces `cnt` to 0 and `phase` to 0, so a newly masked LED starts in its visible half-period.
- **BLINK_MASK = 0:** the prescaler keeps running, but the output is unaffected.
- **Reset values:**
  - DATA = RESET_VALUE, BLINK_MASK = 0, cnt = 0, phase = 0.
  - readdata = 0, out_port = RESET_VALUE.
  - Asserting reset mid-operation returns all state to these values immediately, without waiting for a clock edge.
- **Read mux:** address 0 returns DATA and address 1 returns BLINK_MASK, zero-extended. Addresses 2 and 3 return 0.
- **readdata update:** readdata is updated only when read=1; otherwise it holds its value.
- **Simultaneous read and write in one cycle:** the write takes effect, and readdata returns the pre-write value.
- **Prescaler wrap in the same cycle as a BLINK_MASK write:** the write wins, giving cnt=0 and phase=0.

## Timing
- **Write in cycle N:** DATA or BLINK_MASK holds its new value after the rising edge ending cycle N.
- **out_port:** computed from the next-state DATA, BLINK_MASK and phase, so it changes on that same edge (1-cycle write-to-pin latency).
- **Read in cycle N:** readdata is valid in cycle N+1 (fixed read latency 1, no waitrequest).
- **Blink cadence:**
  - phase is high for exactly BLINK_DIV cycles, then low for exactly BLINK_DIV cycles.
  - out_port transitions on the same edge as phase.
- **Counter width:** cnt is $clog2(BLINK_DIV) bits, and the comparison against BLINK_DIV-1 is done at full width.

## Structure
- **Package `de1_soc_leds_pkg`:**
  - Address constants ADDR_DATA=0, ADDR_BLINK=1, ADDR_SET=2, ADDR_CLR=3.
  - A function computing the counter width from BLINK_DIV.
- **Sub-module `de1_soc_blink_prescaler`:**
  - Parameter: BLINK_DIV.
  - Ports: clk, reset, restart, phase.
  - Contains cnt and the phase toggle.
- **Top level:** contains the registers, the read mux and the output register.

## Test plan
Use WIDTH=10, BLINK_DIV=4 and RESET_VALUE=10'h005 for every scenario.
- **Reset:** assert reset asynchronously mid-cycle → out_port=0x005 and readdata=0 immediately. After release, a read of address 0 → 0x005.
- **Write and readback:** write 0x3A5 to address 0 at cycle N → out_port=0x3A5 at cycle N+1. Read address 0 → readdata=0x3A5 one cycle later. Read address 2 → 0.
- **Set/clear:** with DATA=0x0F0, write 0x00F to OUTSET → DATA=0x0FF. Then write 0x0F0 to OUTCLEAR → DATA=0x00F. Writedata bits [31:10]=1 on both writes → no effect.
- **Blink:** with DATA=0x3FF, write 0x001 to BLINK_MASK → out_port=0x3FF for 4 cycles, then 0x3FE for 4 cycles, repeating. A BLINK_MASK rewrite during the blanked half → out_port=0x3FF on the next edge, and the count restarts.
- **Same-cycle read and write:** with DATA=0x111, read and write 0x222 to address 0 in the same cycle → readdata=0x111. A subsequent read → 0x222.

Source files
------------

// File: rtl/de1_soc_leds_pkg.sv
// de1_soc_leds_pkg: shared constants and helpers for the DE1-SoC LED output port.
// Provides the Avalon word-address map and the blink counter width function.
// No ports; imported by de1_soc_leds and de1_soc_blink_prescaler.
package de1_soc_leds_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_BLINK = 2'd1;
  localparam logic [1:0] ADDR_SET   = 2'd2;
  localparam logic [1:0] ADDR_CLR   = 2'd3;

  // Width of a counter that runs 0..div-1. div=2 gives $clog2=1, so the
  // guard only matters for illegal values below 2 and keeps the width nonzero.
  function automatic int cnt_width(input int div);
    if (div <= 2) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/de1_soc_blink_prescaler.sv
// de1_soc_blink_prescaler: free-running blink half-period counter and phase bit.
// Ports: clk, reset (async, active-high), restart (sync clear to cnt=0/phase=0),
//        phase (registered blink phase), phase_next (next-state phase for output regs).
module de1_soc_blink_prescaler
  import de1_soc_leds_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase,
  output logic phase_next
);

  localparam int CW = cnt_width(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          wrap;

  assign wrap = (cnt == CNT_LAST);

  // restart has priority over a wrap landing in the same cycle, so a fresh
  // mask always begins in the visible half-period.
  always_comb begin
    cnt_next   = cnt + 1'b1;
    phase_next = phase;
    if (restart) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (wrap) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/de1_soc_leds.sv
// de1_soc_leds: Avalon-MM LED output port with DATA, BLINK_MASK, OUTSET and OUTCLEAR.
// Ports: clk, reset (async, active-high), address/write/writedata/read (Avalon slave,
//        no wait states), readdata (registered, latency 1), out_port (registered LED drive).
module de1_soc_leds
  import de1_soc_leds_pkg::*;
#(
  parameter int          WIDTH       = 10,
  parameter int          BLINK_DIV   = 25_000_000,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic             read,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_mux;
  logic             restart;
  logic             phase;
  logic             phase_next;

  // Bits above WIDTH are architecturally ignored.
  logic unused_wd;
  assign unused_wd = ^{1'b0, writedata};
  assign wd = writedata[WIDTH-1:0];

  always_comb begin
    data_next = data_q;
    mask_next = mask_q;
    restart   = 1'b0;
    if (write) begin
      case (address)
        ADDR_DATA:  data_next = wd;
        ADDR_BLINK: begin
          mask_next = wd;
          restart   = 1'b1;
        end
        ADDR_SET:   data_next = data_q | wd;
        ADDR_CLR:   data_next = data_q & ~wd;
        default:    data_next = data_q;
      endcase
    end
  end

  // Read mux sees the current registers, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:  rd_mux = 32'(data_q);
      ADDR_BLINK: rd_mux = 32'(mask_q);
      default:    rd_mux = '0;
    endcase
  end

  de1_soc_blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .phase      (phase),
    .phase_next (phase_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RST_DATA;
      mask_q   <= '0;
      readdata <= '0;
      out_port <= RST_DATA;
    end else begin
      data_q   <= data_next;
      mask_q   <= mask_next;
      if (read) readdata <= rd_mux;
      // Built from next-state values so the pin moves on the same edge as
      // the register write or the phase toggle.
      out_port <= data_next & ~(mask_next & {WIDTH{phase_next}});
    end
  end

  logic unused_phase;
  assign unused_phase = phase;

endmodule
